// File: rtl/inst_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of the RV32I instruction encoder.
interface inst_encoder_if;
  // Producer side: instruction field bundle
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [3:0]  in_funct;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [20:0] in_imm;
  // Consumer side: FIFO head
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;

  // Program generator / loader and instruction-memory side
  modport master (
    output in_valid, in_kind, in_funct, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  // Encoder side
  modport slave (
    input  in_valid, in_kind, in_funct, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder: packs field bundles into 32-bit words,
// replaces out-of-range requests with a flagged NOP, and queues results in a
// 2-entry FIFO with accept/illegal statistics counters.
module inst_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  inst_encoder_if.slave    bus,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned INST_W  = 32;
  localparam int unsigned ENTRY_W = INST_W + 1;
  localparam int unsigned OCC_W   = 2;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [2:0] {
    K_R    = 3'd0,
    K_IALU = 3'd1,
    K_LW   = 3'd2,
    K_SW   = 3'd3,
    K_BEQ  = 3'd4,
    K_JAL  = 3'd5,
    K_JALR = 3'd6,
    K_RSVD = 3'd7
  } kind_e;

  logic [ENTRY_W-1:0] mem_q [2];
  logic [ENTRY_W-1:0] mem_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   inst_cnt_q, inst_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [INST_W-1:0]  raw_c;
  logic [INST_W-1:0]  enc_c;
  logic               legal_c;
  logic               imm12_ok_c;
  logic               imm13_ok_c;
  logic               push_c;
  logic               pop_c;

  assign push_c = bus.in_valid & in_ready_q;
  assign pop_c  = out_valid_q & bus.out_ready;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = mem_q[rd_ptr_q][INST_W-1:0];
  assign bus.out_err   = mem_q[rd_ptr_q][INST_W];
  assign inst_count    = inst_cnt_q;
  assign err_count     = err_cnt_q;

  // Field packing and immediate legality; illegal requests become a NOP
  always_comb begin
    raw_c      = NOP_INST;
    legal_c    = 1'b0;
    // 12-bit signed range: bits above 11 are pure sign extension
    imm12_ok_c = (bus.in_imm[20:11] == {10{bus.in_imm[11]}});
    // 13-bit signed range for branches, evenness checked separately
    imm13_ok_c = (bus.in_imm[20:12] == {9{bus.in_imm[12]}});
    case (kind_e'(bus.in_kind))
      K_R: begin
        raw_c   = {1'b0, bus.in_funct[3], 5'b0, bus.in_rs2, bus.in_rs1,
                   bus.in_funct[2:0], bus.in_rd, OP_R};
        legal_c = 1'b1;
      end
      K_IALU: begin
        raw_c   = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct[2:0], bus.in_rd, OP_IALU};
        legal_c = imm12_ok_c;
      end
      K_LW: begin
        raw_c   = {bus.in_imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, OP_LOAD};
        legal_c = imm12_ok_c;
      end
      K_SW: begin
        raw_c   = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010,
                   bus.in_imm[4:0], OP_STOR};
        legal_c = imm12_ok_c;
      end
      K_BEQ: begin
        raw_c   = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000,
                   bus.in_imm[4:1], bus.in_imm[11], OP_BR};
        legal_c = imm13_ok_c & ~bus.in_imm[0];
      end
      K_JAL: begin
        raw_c   = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                   bus.in_imm[19:12], bus.in_rd, OP_JAL};
        legal_c = ~bus.in_imm[0];
      end
      K_JALR: begin
        raw_c   = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, OP_JALR};
        legal_c = imm12_ok_c;
      end
      default: begin
        raw_c   = NOP_INST;
        legal_c = 1'b0;
      end
    endcase
    enc_c = legal_c ? raw_c : NOP_INST;
  end

  // FIFO pointer/occupancy/storage and counter next-state
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    inst_cnt_d  = inst_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = {~legal_c, enc_c};
      wr_ptr_d        = ~wr_ptr_q;
      inst_cnt_d      = inst_cnt_q + CNT_W'(1);
      if (!legal_c) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
    if (pop_c) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_c, pop_c})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    // Handshake flags are registered copies of the next occupancy
    in_ready_d  = (occ_d != OCC_W'(2));
    out_valid_d = (occ_d != OCC_W'(0));
  end

  // State registers; reset discards queued words and clears statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      inst_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      inst_cnt_q  <= inst_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: expected words are queued when a bundle
// is accepted and compared when the FIFO head is consumed.
module tb_inst_encoder;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] inst_count;
  logic [CNT_W-1:0] err_count;

  inst_encoder_if bus ();

  inst_encoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .inst_count (inst_count),
    .err_count  (err_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [32:0] sb_q [$];
  logic [CNT_W-1:0] m_inst;
  logic [CNT_W-1:0] m_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it differs
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Consumer-side scoreboard: compare on pop, and hold-check the head while stalled
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_word", 64'(bus.out_inst), 64'hFFFF_FFFF_FFFF);
      end else if (bus.out_ready) begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("out_inst", 64'(bus.out_inst), 64'(e[31:0]));
        chk("out_err", 64'(bus.out_err), 64'(e[32]));
      end else begin
        chk("stall_head", 64'({bus.out_err, bus.out_inst}), 64'(sb_q[0]));
      end
    end
  end

  // Offer one bundle and wait (bounded) for its accept
  task automatic send(input logic [2:0] k, input logic [3:0] f, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input int imm,
                      input logic [31:0] exp_inst, input logic exp_err);
    bit done;
    done = 1'b0;
    bus.in_kind  = k;
    bus.in_funct = f;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = 21'(imm);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb_q.push_back({exp_err, exp_inst});
        m_inst = m_inst + CNT_W'(1);
        if (exp_err) m_err = m_err + CNT_W'(1);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 64'(0), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  // Let the consumer take everything queued (bounded)
  task automatic drain();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && sb_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    chk("drain_left", 64'(sb_q.size()), 64'(0));
    chk("drain_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // Pulse reset asynchronously and check the cleared state before any edge
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_inst_count", 64'(inst_count), 64'(0));
    chk("rst_err_count", 64'(err_count), 64'(0));
    chk("rst_out_inst", 64'(bus.out_inst), 64'(0));
    chk("rst_out_err", 64'(bus.out_err), 64'(0));
    sb_q.delete();
    m_inst = '0;
    m_err  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_kind   = '0;
    bus.in_funct  = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b1;
    m_inst        = '0;
    m_err         = '0;
    #12;
    do_reset();

    // R add / sub with latency and no-bypass checks
    chk("idle_valid", 64'(bus.out_valid), 64'(0));
    send(3'd0, 4'b0000, 5'd3, 5'd1, 5'd2, 12345, 32'h0020_81B3, 1'b0);
    chk("latency_valid", 64'(bus.out_valid), 64'(1));
    send(3'd0, 4'b1000, 5'd3, 5'd1, 5'd2, 0, 32'h4020_81B3, 1'b0);

    // Immediate forms
    send(3'd1, 4'b0000, 5'd5, 5'd0, 5'd0, -1,   32'hFFF0_0293, 1'b0);
    send(3'd3, 4'b0000, 5'd0, 5'd1, 5'd2, 8,    32'h0020_A423, 1'b0);
    send(3'd4, 4'b0000, 5'd0, 5'd1, 5'd2, -4,   32'hFE20_8EE3, 1'b0);
    send(3'd5, 4'b0000, 5'd1, 5'd0, 5'd0, 2048, 32'h0010_00EF, 1'b0);
    send(3'd2, 4'b0000, 5'd4, 5'd5, 5'd0, -8,   32'hFF82_A203, 1'b0);
    send(3'd6, 4'b0000, 5'd0, 5'd1, 5'd0, 0,    32'h0000_8067, 1'b0);

    // Range boundaries
    send(3'd1, 4'b0000, 5'd1, 5'd0, 5'd0, 2047,  32'h7FF0_0093, 1'b0);
    send(3'd1, 4'b0000, 5'd1, 5'd0, 5'd0, -2048, 32'h8000_0093, 1'b0);
    send(3'd1, 4'b0000, 5'd1, 5'd0, 5'd0, -2049, 32'h0000_0013, 1'b1);
    send(3'd4, 4'b0000, 5'd0, 5'd0, 5'd0, -4096, 32'h8000_0063, 1'b0);
    send(3'd4, 4'b0000, 5'd0, 5'd0, 5'd0, 4094,  32'h7E00_0FE3, 1'b0);
    send(3'd4, 4'b0000, 5'd0, 5'd0, 5'd0, 4096,  32'h0000_0013, 1'b1);
    send(3'd5, 4'b0000, 5'd1, 5'd0, 5'd0, 1,     32'h0000_0013, 1'b1);
    chk("cnt_inst_run", 64'(inst_count), 64'(m_inst));
    chk("cnt_err_run", 64'(err_count), 64'(m_err));
    drain();

    // Illegal requests from a clean start
    do_reset();
    send(3'd4, 4'b0000, 5'd0, 5'd1, 5'd2, 3,    32'h0000_0013, 1'b1);
    send(3'd1, 4'b0000, 5'd1, 5'd0, 5'd0, 2048, 32'h0000_0013, 1'b1);
    send(3'd7, 4'b0000, 5'd1, 5'd2, 5'd3, 0,    32'h0000_0013, 1'b1);
    chk("illegal_err_count", 64'(err_count), 64'(3));
    chk("illegal_inst_count", 64'(inst_count), 64'(3));
    drain();

    // Backpressure: two fill the FIFO, third is held until a pop
    bus.out_ready = 1'b0;
    send(3'd0, 4'b0000, 5'd10, 5'd11, 5'd12, 0, 32'h00C5_8533, 1'b0);
    send(3'd0, 4'b1000, 5'd10, 5'd11, 5'd12, 0, 32'h40C5_8533, 1'b0);
    @(negedge clk);
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    fork
      send(3'd1, 4'b0000, 5'd7, 5'd0, 5'd0, 100, 32'h0640_0393, 1'b0);
      begin
        repeat (3) @(negedge clk);
        chk("held_in_ready", 64'(bus.in_ready), 64'(0));
        chk("held_queue", 64'(sb_q.size()), 64'(2));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Sustained stream with out_ready=1: push and pop together at occupancy 1
    for (int i = 1; i <= 6; i++) begin
      send(3'd1, 4'b0000, 5'd1, 5'd0, 5'd0, i, (32'(i) << 20) | 32'h0000_0093, 1'b0);
      if (i > 1) chk("stream_valid", 64'(bus.out_valid), 64'(1));
    end
    drain();

    // Reset mid-stream with two entries queued
    bus.out_ready = 1'b0;
    send(3'd1, 4'b0000, 5'd1, 5'd0, 5'd0, 1, 32'h0010_0093, 1'b1 ^ 1'b1);
    send(3'd1, 4'b0000, 5'd1, 5'd0, 5'd0, 5000, 32'h0000_0013, 1'b1);
    chk("pre_rst_inst", 64'(inst_count), 64'(m_inst));
    do_reset();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk);
    #1;

    // Counter wrap: 17 accepts on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      send(3'd1, 4'b0000, 5'd1, 5'd0, 5'd0, i, (32'(i) << 20) | 32'h0000_0093, 1'b0);
    end
    chk("wrap_inst_count", 64'(inst_count), 64'(1));
    chk("wrap_err_count", 64'(err_count), 64'(0));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
